// File: rtl/cpu_pkg.sv
// Shared types for the pipeline sequencer: FSM states, PC source encodings,
// per-cycle pipeline control word and default parameter values.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_MEM_WAIT   = 2'd1,
      ST_HALT_DRAIN = 2'd2,
      ST_HALTED     = 2'd3
   } seq_state_t;

   localparam logic [1:0] PC_SRC_INC = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam int DRAIN_CYCLES_DEF = 2;
   localparam int STALL_CNT_W_DEF  = 8;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] pc_src;
      logic       if_id_en;
      logic       id_ex_en;
      logic       ex_m_en;
      logic       if_id_flush;
      logic       id_ex_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, pc_src: PC_SRC_INC, if_id_en: 1'b1, id_ex_en: 1'b1,
                                     ex_m_en: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
   localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, pc_src: PC_SRC_BR, if_id_en: 1'b1, id_ex_en: 1'b1,
                                     ex_m_en: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
   localparam ctrl_t CTRL_JUMP   = '{pc_en: 1'b1, pc_src: PC_SRC_JMP, if_id_en: 1'b1, id_ex_en: 1'b1,
                                     ex_m_en: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0};
   // Front end frozen, bubble injected, back end keeps retiring.
   localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, pc_src: PC_SRC_INC, if_id_en: 1'b0, id_ex_en: 1'b1,
                                     ex_m_en: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
   localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, pc_src: PC_SRC_INC, if_id_en: 1'b0, id_ex_en: 1'b0,
                                     ex_m_en: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
   localparam ctrl_t CTRL_RESET  = '{pc_en: 1'b0, pc_src: PC_SRC_INC, if_id_en: 1'b0, id_ex_en: 1'b0,
                                     ex_m_en: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard/control requests into the sequencer and pipeline register controls out.
// The sequencer side uses the slave modport; the requester/observer side uses master.
interface pipeline_sequencer_if #(
   parameter int STALL_CNT_W = cpu_pkg::STALL_CNT_W_DEF
);
   logic                   hazard_in;
   logic                   branch_taken_EX;
   logic                   jump_ID;
   logic                   halt_ID;
   logic                   mem_busy;
   logic                   resume;
   logic                   PC_en;
   logic [1:0]             PC_src;
   logic                   IF_ID_en;
   logic                   ID_EX_en;
   logic                   EX_M_en;
   logic                   IF_ID_flush;
   logic                   ID_EX_bubble;
   logic                   halted;
   logic [STALL_CNT_W-1:0] stall_count;

   modport slave (
      input  hazard_in, branch_taken_EX, jump_ID, halt_ID, mem_busy, resume,
      output PC_en, PC_src, IF_ID_en, ID_EX_en, EX_M_en, IF_ID_flush, ID_EX_bubble,
             halted, stall_count
   );

   modport master (
      output hazard_in, branch_taken_EX, jump_ID, halt_ID, mem_busy, resume,
      input  PC_en, PC_src, IF_ID_en, ID_EX_en, EX_M_en, IF_ID_flush, ID_EX_bubble,
             halted, stall_count
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         i_inc,
   input  logic         i_clr,
   output logic [W-1:0] o_count
);
   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clr)
         r_count <= '0;
      else if (i_inc && (r_count != '1))
         r_count <= r_count + W'(1);
   end

   assign o_count = r_count;
endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline control FSM: combinational stall/flush/PC-select from state and requests,
// zero-latency decisions; mem_busy freezes every pipeline register.
module pipeline_sequencer
   import cpu_pkg::*;
#(
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int STALL_CNT_W  = STALL_CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_sequencer_if.slave  bus
);
   localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

   seq_state_t             r_state;
   seq_state_t             w_next;
   logic [DW-1:0]          r_drain;
   logic [DW-1:0]          w_drain_next;
   ctrl_t                  w_ctrl;
   logic                   w_stall_inc;
   logic [STALL_CNT_W-1:0] w_stall_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_drain <= '0;
      end else begin
         r_state <= w_next;
         r_drain <= w_drain_next;
      end
   end

   always_comb begin
      w_ctrl       = CTRL_RUN;
      w_next       = r_state;
      w_drain_next = r_drain;
      case (r_state)
         // MEM_WAIT with memory ready behaves exactly like RUN in the same cycle.
         ST_RUN, ST_MEM_WAIT: begin
            w_next = ST_RUN;
            if (bus.mem_busy) begin
               w_ctrl = CTRL_FREEZE;
               w_next = ST_MEM_WAIT;
            end else if (bus.branch_taken_EX) begin
               w_ctrl = CTRL_BRANCH;
            end else if (bus.jump_ID) begin
               w_ctrl = CTRL_JUMP;
            end else if (bus.hazard_in) begin
               w_ctrl = CTRL_STALL;
            end else if (bus.halt_ID) begin
               w_ctrl       = CTRL_STALL;
               w_drain_next = DW'(DRAIN_CYCLES);
               w_next       = ST_HALT_DRAIN;
            end
         end
         ST_HALT_DRAIN: begin
            if (bus.mem_busy) begin
               w_ctrl = CTRL_FREEZE;
            end else if (bus.branch_taken_EX) begin
               w_ctrl = CTRL_BRANCH;
               w_next = ST_RUN;
            end else begin
               w_ctrl       = CTRL_STALL;
               w_drain_next = r_drain - DW'(1);
               if (r_drain <= DW'(1))
                  w_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            w_ctrl = CTRL_FREEZE;
            if (bus.resume)
               w_next = ST_RUN;
         end
         default: w_next = ST_RUN;
      endcase
      if (rst)
         w_ctrl = CTRL_RESET;
   end

   assign w_stall_inc = !w_ctrl.pc_en && (r_state != ST_HALTED);

   sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
      .clk     (clk),
      .i_inc   (w_stall_inc),
      .i_clr   (rst),
      .o_count (w_stall_count)
   );

   assign bus.PC_en        = w_ctrl.pc_en;
   assign bus.PC_src       = w_ctrl.pc_src;
   assign bus.IF_ID_en     = w_ctrl.if_id_en;
   assign bus.ID_EX_en     = w_ctrl.id_ex_en;
   assign bus.EX_M_en      = w_ctrl.ex_m_en;
   assign bus.IF_ID_flush  = w_ctrl.if_id_flush;
   assign bus.ID_EX_bubble = w_ctrl.id_ex_bubble;
   assign bus.halted       = (r_state == ST_HALTED) && !rst;
   assign bus.stall_count  = w_stall_count;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboarded bench: directed scenarios then random traffic against a flag-based model.
module tb_pipeline_sequencer;
   localparam int W     = 8;
   localparam int DRAIN = 2;
   localparam int MAXC  = (1 << W) - 1;

   typedef struct packed {
      logic         pc_en;
      logic [1:0]   pc_src;
      logic         if_id_en;
      logic         id_ex_en;
      logic         ex_m_en;
      logic         flush;
      logic         bubble;
      logic         halted;
      logic [W-1:0] stall;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipeline_sequencer_if #(.STALL_CNT_W(W)) bus ();

   pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .STALL_CNT_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   // Reference model: just "halted", "draining" and cycles left; MEM_WAIT needs no flag.
   bit m_halted   = 1'b0;
   bit m_draining = 1'b0;
   int m_left     = 0;
   int m_stall    = 0;

   function automatic obs_t mk(bit pc_en, logic [1:0] src, bit ifid, bit idex, bit exm,
                               bit fl, bit bub, bit hlt);
      obs_t o;
      o.pc_en    = pc_en;
      o.pc_src   = src;
      o.if_id_en = ifid;
      o.id_ex_en = idex;
      o.ex_m_en  = exm;
      o.flush    = fl;
      o.bubble   = bub;
      o.halted   = hlt;
      o.stall    = '0;
      return o;
   endfunction

   task automatic step(input bit r, input bit hz, input bit br, input bit jp, input bit ht,
                       input bit mb, input bit rs, input bit chk, input string tag);
      obs_t e;
      bit   was_halted;
      @(posedge clk);
      #1;
      rst                 = r;
      bus.hazard_in       = hz;
      bus.branch_taken_EX = br;
      bus.jump_ID         = jp;
      bus.halt_ID         = ht;
      bus.mem_busy        = mb;
      bus.resume          = rs;
      was_halted = m_halted;
      if (r) begin
         e = mk(0, 2'b00, 0, 0, 0, 1, 1, 0);
      end else if (m_halted) begin
         e = mk(0, 2'b00, 0, 0, 0, 0, 0, 1);
         if (rs) m_halted = 1'b0;
      end else if (mb) begin
         e = mk(0, 2'b00, 0, 0, 0, 0, 0, 0);
      end else if (br) begin
         e = mk(1, 2'b01, 1, 1, 1, 1, 1, 0);
         m_draining = 1'b0;
      end else if (m_draining) begin
         e = mk(0, 2'b00, 0, 1, 1, 0, 1, 0);
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_draining = 1'b0;
            m_halted   = 1'b1;
         end
      end else if (jp) begin
         e = mk(1, 2'b10, 1, 1, 1, 1, 0, 0);
      end else if (hz) begin
         e = mk(0, 2'b00, 0, 1, 1, 0, 1, 0);
      end else if (ht) begin
         e = mk(0, 2'b00, 0, 1, 1, 0, 1, 0);
         m_draining = 1'b1;
         m_left     = DRAIN;
      end else begin
         e = mk(1, 2'b00, 1, 1, 1, 0, 0, 0);
      end
      e.stall = W'(m_stall);
      if (r) begin
         m_halted   = 1'b0;
         m_draining = 1'b0;
         m_left     = 0;
         m_stall    = 0;
      end else if (!e.pc_en && !was_halted && m_stall < MAXC) begin
         m_stall = m_stall + 1;
      end
      if (chk) begin
         exp_q.push_back(e);
         tag_q.push_back(tag);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, tag);
   endtask

   always @(negedge clk) begin
      obs_t  e;
      obs_t  g;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         g.pc_en    = bus.PC_en;
         g.pc_src   = bus.PC_src;
         g.if_id_en = bus.IF_ID_en;
         g.id_ex_en = bus.ID_EX_en;
         g.ex_m_en  = bus.EX_M_en;
         g.flush    = bus.IF_ID_flush;
         g.bubble   = bus.ID_EX_bubble;
         g.halted   = bus.halted;
         g.stall    = bus.stall_count;
         n_checks++;
         if (g === e)
            n_pass++;
         else
            $display("FAIL %s @%0t: pcen/src/ifid/idex/exm/flush/bub/halted=%b/%b/%b/%b/%b/%b/%b/%b stall=%0d, required %b/%b/%b/%b/%b/%b/%b/%b stall=%0d",
                     t, $time, g.pc_en, g.pc_src, g.if_id_en, g.id_ex_en, g.ex_m_en, g.flush,
                     g.bubble, g.halted, g.stall, e.pc_en, e.pc_src, e.if_id_en, e.id_ex_en,
                     e.ex_m_en, e.flush, e.bubble, e.halted, e.stall);
      end
   end

   initial begin
      bus.hazard_in       = 1'b0;
      bus.branch_taken_EX = 1'b0;
      bus.jump_ID         = 1'b0;
      bus.halt_ID         = 1'b0;
      bus.mem_busy        = 1'b0;
      bus.resume          = 1'b0;
      repeat (2) @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset_hold");
      step(1, 1, 1, 1, 1, 1, 1, 1, "reset_inputs");
      idle(1, "first_run");

      step(0, 1, 0, 0, 0, 0, 0, 1, "hazard_c1");
      step(0, 1, 0, 0, 0, 0, 0, 1, "hazard_c2");
      idle(1, "hazard_count2");

      step(0, 1, 1, 1, 0, 0, 0, 1, "br_jp_hz");
      step(0, 0, 0, 1, 0, 0, 0, 1, "jump");

      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 1, 0, 1, "membusy_br");
      step(0, 0, 1, 0, 0, 0, 0, 1, "memwait_release_br");

      step(0, 0, 0, 0, 1, 0, 0, 1, "halt_id");
      idle(2, "halt_drain");
      step(0, 1, 1, 1, 1, 1, 0, 1, "halted_ignore");
      step(0, 0, 0, 0, 0, 0, 1, 1, "resume");
      idle(2, "after_resume");

      step(0, 0, 0, 0, 1, 0, 0, 1, "halt_id2");
      step(0, 0, 1, 0, 0, 0, 0, 1, "drain_branch");
      idle(3, "abandoned_halt");

      step(0, 0, 0, 0, 1, 0, 0, 1, "halt_id3");
      step(0, 0, 0, 0, 0, 1, 0, 1, "drain_membusy");
      idle(3, "drain_resumed");
      step(0, 0, 0, 0, 0, 1, 0, 1, "mw_enter");
      step(1, 0, 0, 0, 0, 1, 0, 1, "reset_in_memwait");
      idle(1, "after_mw_reset");

      for (int i = 0; i < 260; i++) step(0, 1, 0, 0, 0, 0, 0, 1, "sat_stall");
      idle(1, "sat_value");
      step(0, 0, 0, 0, 1, 0, 0, 1, "sat_halt");
      idle(3, "sat_drain_halted");
      step(1, 0, 0, 0, 0, 0, 0, 1, "reset_in_halted");
      idle(2, "after_halted_reset");

      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0, 1, "random");

      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2: cycles allowed for older instructions to retire after a halt.
REQ-002 Parameter STALL_CNT_W, default 8: width of the stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 hazard_in  in  1  load-use stall request from the hazard detector.
REQ-006 branch_taken_EX  in  1  branch resolved taken in EX.
REQ-007 jump_ID  in  1  unconditional jump decoded in ID.
REQ-008 halt_ID  in  1  halt instruction decoded in ID.
REQ-009 mem_busy  in  1  data memory not ready this cycle.
REQ-010 resume  in  1  restart request while halted.
REQ-011 PC_en  out  1  PC register load enable.
REQ-012 PC_src  out  2  00 PC+1, 01 branch target, 10 jump target, 11 unused.
REQ-013 IF_ID_en, ID_EX_en, EX_M_en  out  1 each  pipeline register enables.
REQ-014 IF_ID_flush  out  1  clear IF/ID to NOP.
REQ-015 ID_EX_bubble  out  1  load NOP into ID/EX.
REQ-016 halted  out  1  high in HALTED state.
REQ-017 stall_count  out  STALL_CNT_W  saturating count of stalled cycles.

Function
REQ-018 States RUN, MEM_WAIT, HALT_DRAIN, HALTED; outputs combinational from state and inputs; state, drain counter and stall_count registered.
REQ-019 RUN default: all enables 1, PC_src 00, flush/bubble 0.
REQ-020 RUN priority: mem_busy > branch_taken_EX > jump_ID > hazard_in > halt_ID.
REQ-021 RUN+mem_busy: all four enables 0, no flush/bubble, next MEM_WAIT.
REQ-022 RUN+branch_taken_EX: PC_en 1, PC_src 01, IF_ID_flush 1, ID_EX_bubble 1; jump/hazard/halt ignored that cycle; stay RUN.
REQ-023 RUN+jump_ID: PC_en 1, PC_src 10, IF_ID_flush 1; stay RUN.
REQ-024 RUN+hazard_in: PC_en 0, IF_ID_en 0, ID_EX_bubble 1; stay RUN (one-cycle penalty per asserted cycle).
REQ-025 RUN+halt_ID: PC_en 0, IF_ID_en 0, ID_EX_bubble 1; load drain counter with DRAIN_CYCLES; next HALT_DRAIN.
REQ-026 MEM_WAIT: mem_busy 1 -> all enables 0, stay; mem_busy 0 -> apply RUN rules same cycle, next state per RUN rules.
REQ-027 HALT_DRAIN: PC_en 0, IF_ID_en 0, ID_EX_bubble 1, ID_EX_en 1, EX_M_en 1; decrement counter; next HALTED when counter reaches 0.
REQ-028 HALT_DRAIN+mem_busy: all enables 0, counter held.
REQ-029 HALT_DRAIN+branch_taken_EX (mem_busy 0): halt abandoned; REQ-022 outputs; next RUN.
REQ-030 HALTED: all enables 0; resume -> next RUN, PC_en 1 from following cycle; other inputs ignored.
REQ-031 stall_count increments in any cycle with PC_en 0, state not HALTED, rst 0; saturates at 2^STALL_CNT_W-1.

Reset
REQ-032 While rst 1: all enables 0, IF_ID_flush 1, ID_EX_bubble 1, PC_src 00, halted 0.
REQ-033 Edge with rst 1: state RUN, drain counter 0, stall_count 0, regardless of state (mid-drain, MEM_WAIT, HALTED).
REQ-034 First cycle after rst deasserts: RUN rules apply.

Structure
REQ-035 Shared package cpu_pkg holds state enum, PC_src encodings (PC_SRC_INC/BR/JMP), DRAIN_CYCLES and STALL_CNT_W defaults.
REQ-036 One sub-module sat_counter (parameterised width, inc/clr, saturate) implements stall_count.

Verification
REQ-037 RUN, hazard_in 1 for 2 cycles -> PC_en 0, IF_ID_en 0, ID_EX_bubble 1 both cycles; stall_count 0->2.
REQ-038 branch_taken_EX, jump_ID, hazard_in 1 together -> PC_src 01, IF_ID_flush 1, ID_EX_bubble 1, PC_en 1.
REQ-039 mem_busy 1 for 3 cycles with branch_taken_EX held -> enables 0 three cycles; 4th cycle PC_src 01, PC_en 1.
REQ-040 halt_ID -> 2 drain cycles (EX_M_en 1), then halted 1; resume -> halted 0 next cycle, PC_en 1 after.
REQ-041 halt_ID, then branch_taken_EX on first drain cycle -> REQ-022 outputs, halted never 1.
REQ-042 255 stall cycles plus 5 more -> stall_count 255; rst 1 in HALTED -> stall_count 0, state RUN.
